// File: rtl/mat_mul_pkg.sv
// Shared types and constant helpers for the pipelined matrix multiplier.
// Element offsets return the MSB index of an element in a row-major flat vector.
package mat_mul_pkg;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } sat_mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Element [r][c] of a rows x cols matrix sits in the MSBs when r = c = 0.
  function automatic int elem_off(input int r, input int c, input int rows,
                                  input int cols, input int w);
    return (rows * cols - r * cols - c) * w - 1;
  endfunction

  function automatic int a_off(input int i, input int k, input int m,
                               input int kk, input int dw);
    return elem_off(i, k, m, kk, dw);
  endfunction

  function automatic int b_off(input int k, input int j, input int kk,
                               input int n, input int dw);
    return elem_off(k, j, kk, n, dw);
  endfunction

  function automatic int c_off(input int i, input int j, input int m,
                               input int n, input int w);
    return elem_off(i, j, m, n, w);
  endfunction

endpackage

// File: rtl/mat_mul_stage.sv
// One inner-product stage: adds column k of A times row k of B into the
// running M x N accumulators and carries A/B forward for later stages.
module mat_mul_stage
  import mat_mul_pkg::*;
#(
  parameter int M     = 5,
  parameter int N     = 4,
  parameter int DW    = 12,
  parameter int AW    = 25,
  parameter int CAW   = 120,
  parameter int CBW   = 96,
  parameter bit FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              v_in,
  input  logic [CAW-1:0]    a_in,
  input  logic [CBW-1:0]    b_in,
  input  logic [M*DW-1:0]   a_col,
  input  logic [N*DW-1:0]   b_row,
  input  logic [M*N*AW-1:0] acc_in,
  output logic              v,
  output logic [M*N*AW-1:0] acc,
  output logic [CAW-1:0]    a_q,
  output logic [CBW-1:0]    b_q
);

  logic [M*N*AW-1:0] acc_d;
  logic [AW-1:0]     prod;
  logic [AW-1:0]     base;

  always_comb begin
    acc_d = '0;
    prod  = '0;
    base  = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        prod = AW'(a_col[(M-i)*DW-1 -: DW]) * AW'(b_row[(N-j)*DW-1 -: DW]);
        base = FIRST ? '0 : acc_in[c_off(i, j, M, N, AW) -: AW];
        acc_d[c_off(i, j, M, N, AW) -: AW] = base + prod;
      end
    end
  end

  // A bubble may overwrite this stage's data; its valid bit marks it unused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v   <= 1'b0;
      acc <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (adv) begin
      v   <= v_in;
      acc <= acc_d;
      a_q <= a_in;
      b_q <= b_in;
    end
  end

endmodule

// File: rtl/mat_mul_pipe.sv
// Fully pipelined unsigned C = A*B, one inner-product term per stage,
// valid/ready at both ends and a wrap-or-saturate output.
module mat_mul_pipe
  import mat_mul_pkg::*;
#(
  parameter int M   = 5,
  parameter int K   = 2,
  parameter int N   = 4,
  parameter int DW  = 12,
  parameter int OW  = 12,
  parameter int SAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M*K*DW-1:0] a_flat,
  input  logic [K*N*DW-1:0] b_flat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M*N*OW-1:0] c_flat,
  output logic              busy,
  output logic [15:0]       done_cnt
);

  // Handshake: a transfer happens on any rising edge where valid && ready;
  // c_flat holds steady while out_valid && !out_ready.
  localparam int AW  = 2 * DW + clog2(K);
  localparam int CAW = M * K * DW;
  localparam int CBW = K * N * DW;
  localparam int CW  = M * N * AW;
  localparam sat_mode_e MODE = (SAT != 0) ? mat_mul_pkg::SAT : mat_mul_pkg::WRAP;

  logic [K-1:0]   v;
  logic [K-1:0]   adv;
  logic [CAW-1:0] a_c   [K];
  logic [CBW-1:0] b_c   [K];
  logic [CW-1:0]  acc_c [K];

  for (genvar s = 0; s < K; s++) begin : g_stage
    logic [CAW-1:0]  a_src;
    logic [CBW-1:0]  b_src;
    logic [CW-1:0]   acc_src;
    logic            v_src;
    logic [M*DW-1:0] a_col;
    logic [N*DW-1:0] b_row;

    if (s == 0) begin : g_head
      assign a_src   = a_flat;
      assign b_src   = b_flat;
      assign acc_src = '0;
      assign v_src   = in_valid;
    end else begin : g_body
      assign a_src   = a_c[s-1];
      assign b_src   = b_c[s-1];
      assign acc_src = acc_c[s-1];
      assign v_src   = v[s-1];
    end

    for (genvar i = 0; i < M; i++) begin : g_acol
      assign a_col[(M-i)*DW-1 -: DW] = a_src[a_off(i, s, M, K, DW) -: DW];
    end
    for (genvar j = 0; j < N; j++) begin : g_brow
      assign b_row[(N-j)*DW-1 -: DW] = b_src[b_off(s, j, K, N, DW) -: DW];
    end

    // A stage stalls only if it and every stage after it is full and the sink stalls.
    assign adv[s] = out_ready || !(&v[K-1:s]);

    mat_mul_stage #(
      .M(M), .N(N), .DW(DW), .AW(AW), .CAW(CAW), .CBW(CBW), .FIRST(s == 0)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv    (adv[s]),
      .v_in   (v_src),
      .a_in   (a_src),
      .b_in   (b_src),
      .a_col  (a_col),
      .b_row  (b_row),
      .acc_in (acc_src),
      .v      (v[s]),
      .acc    (acc_c[s]),
      .a_q    (a_c[s]),
      .b_q    (b_c[s])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = v[K-1];
  assign busy      = |v;

  logic [AW-1:0] elem;

  always_comb begin
    c_flat = '0;
    elem   = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        elem = acc_c[K-1][c_off(i, j, M, N, AW) -: AW];
        if (MODE == mat_mul_pkg::SAT &&
            ({{(OW+1){1'b0}}, elem} > {{(AW+1){1'b0}}, {OW{1'b1}}}))
          c_flat[c_off(i, j, M, N, OW) -: OW] = '1;
        else
          c_flat[c_off(i, j, M, N, OW) -: OW] = OW'(elem);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_cnt <= '0;
    else if (out_valid && out_ready) done_cnt <= done_cnt + 16'd1;
  end

endmodule

// File: doc/mat_mul_pipe.md
# mat_mul_pipe

Parametrised, fully pipelined unsigned matrix multiplier computing C = A·B for an M×K matrix A and a K×N matrix B, one matrix pair accepted per cycle. The design has one pipeline stage per inner-product term and valid/ready handshakes at both ends. Per-stage occupancy lets bubbles collapse under backpressure. It is the general successor of the fixed-size 12-bit multiplier in the MultMatriz pipeline and feeds downstream consumers through a wrap-or-saturate output.

## Interface

Parameters:
- M, 5: rows of A and C.
- K, 2: inner dimension, equal to the pipeline depth; legal range is K ≥ 1.
- N, 4: columns of B and C.
- DW, 12: input element width.
- OW, 12: output element width.
- SAT, 0: output mode. 0 wraps modulo 2^OW; 1 clamps to 2^OW−1.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  a_flat and b_flat are presented.
- in_ready  out  1  stage 0 can accept this cycle.
- a_flat  in  M·K·DW  matrix A, row-major; element a[0][0] is in the MSBs.
- b_flat  in  K·N·DW  matrix B, row-major; element b[0][0] is in the MSBs.
- out_valid  out  1  c_flat holds a result.
- out_ready  in  1  consumer takes c_flat this cycle.
- c_flat  out  M·N·OW  matrix C, row-major; element c[0][0] is in the MSBs.
- busy  out  1  at least one stage is occupied.
- done_cnt  out  16  number of results consumed, wrapping at 2^16.

## Operation

- Element packing: a[i][k] occupies bits [(M·K−i·K−k)·DW−1 −: DW]. B and C use the same rule with their own dimensions and widths.
- Arithmetic:
  - All values are unsigned.
  - Each product is 2·DW bits wide.
  - Accumulators are AW = 2·DW + clog2(K) bits wide, so they never overflow internally.
- Stage s (0 ≤ s < K):
  - Holds a valid bit v[s], the M×N accumulators acc[s], and copies of a_flat and b_flat for later stages.
  - Stage 0 loads acc[0][i][j] = a[i][0]·b[0][j].
  - Stage s>0 loads acc[s][i][j] = acc[s−1][i][j] + a[i][s]·b[s][j], using the A/B copies carried by stage s−1.
- Per-stage advance (bubble collapse):
  - adv[K−1] = !v[K−1] || out_ready.
  - adv[s] = !v[s] || adv[s+1].
  - in_ready = adv[0].
  - Stage s loads when adv[s]. Its v[s] then takes v[s−1], or in_valid for stage 0.
- Output:
  - out_valid = v[K−1].
  - Each c_flat element is derived combinationally from acc[K−1]. With SAT=0 it is the low OW bits. With SAT=1 it is min(acc, 2^OW−1).
- Handshake rules:
  - A transfer occurs on any edge where valid && ready.
  - c_flat must stay stable while out_valid && !out_ready.
  - Input data is sampled only on in_valid && in_ready.
- done_cnt increments on each out_valid && out_ready edge.
- busy = OR of all v[s].

## Timing

- Latency: with an empty pipeline and out_ready high, a pair accepted at edge e0 appears on out_valid after edge e0+K−1. For K=1 the result is visible the cycle after acceptance.
- Throughput is one result per cycle with out_ready held high.
- Simultaneous events:
  - A full pipeline with out_ready high accepts a new input on the same edge that the last result leaves.
  - With out_ready low, stages holding bubbles still fill; a full pipeline deasserts in_ready in the same cycle.
- Reset:
  - All v[s]=0 and all accumulators are 0.
  - Therefore c_flat=0, out_valid=0, busy=0, done_cnt=0.
  - in_ready=1 once rst_n is high.
- Reset mid-operation discards every in-flight result with no output. The first post-reset input again has K-cycle latency.
- done_cnt wraps from 0xFFFF to 0 with no side effect.

## Structure

- Shared package mat_mul_pkg holds:
  - a constant function clog2;
  - element-offset functions a_off, b_off and c_off;
  - enum sat_mode_e with values WRAP and SAT.
- Sub-module mat_mul_stage is one pipeline stage:
  - Parameters: M, N, DW, AW and FIRST.
  - It holds the valid bit, the accumulator array and the A/B carry.
  - The top generates K instances and the output wrap/saturate logic.

## Test plan

- Default parameters; A all 1, B all 2 → after 2 cycles, every c element is 4; done_cnt=1 after the handshake.
- Back-to-back streaming: 10 random pairs with out_ready=1 → 10 results in consecutive cycles, each matching a reference model, in order.
- Backpressure: out_ready held low for 5 cycles while streaming → in_ready=0 once both stages are full; c_flat stays stable; no result is lost or duplicated after release.
- Saturation: A and B all 4095, DW=OW=12, K=2 → SAT=0 gives every element 2; SAT=1 gives every element 4095.
- Reset mid-stream: assert rst_n low with 2 results in flight → out_valid=0 and busy=0 immediately; after release, no stale result ever appears.
- Alternate shape: M=3, K=3, N=3, SAT=0, identity A with a random B → C equals B after 3 cycles; K=1 build gives 1-cycle latency.
